wb32to16_bridge: RTL
====================

// Module: wb32to16_bridge
// PURPOSE
//  Wishbone initiator on the 16-bit memory bus (drives ram16bit_wb-type responders) and responder on the 32-bit CPU bus.
//  Splits each 32-bit access into up to two 16-bit beats, big-endian: high half at adr[31:2]*4+0, low half at +2.
//  Registered, single outstanding transfer. A watchdog turns a hung beat into an error response.
// PARAMETERS
//  TIMEOUT  1023  cycles a beat may wait for m_wb_ack_i before abort; 0 disables the watchdog
//  TW       10    watchdog counter width; TIMEOUT must be < 2**TW
// PORTS
//  clk_i       in   1   single clock, rising edge
//  rst_i       in   1   reset, asynchronous, active-low
//  s_wb_adr_i  in   32  CPU-side address; bits [1:0] ignored
//  s_wb_dat_i  in   32  CPU write data
//  s_wb_dat_o  out  32  CPU read data, registered
//  s_wb_sel_i  in   4   byte selects; [3:2] select high half, [1:0] select low half
//  s_wb_we_i   in   1   write enable
//  s_wb_cyc_i  in   1   cycle
//  s_wb_stb_i  in   1   strobe
//  s_wb_ack_o  out  1   one-cycle ack
//  s_wb_err_o  out  1   one-cycle error (timeout)
//  m_wb_adr_o  out  32  memory address {adr[31:2], half, 1'b0}
//  m_wb_dat_o  out  16  memory write data
//  m_wb_dat_i  in   16  memory read data
//  m_wb_sel_o  out  2   halfword byte selects
//  m_wb_we_o   out  1   write enable
//  m_wb_cyc_o  out  1   cycle
//  m_wb_stb_o  out  1   strobe
//  m_wb_ack_i  in   1   memory ack
// BEHAVIOUR
//  Reset (rst_i=0, any time, mid-beat included): state=IDLE; all outputs 0; s_wb_dat_o=0; latched request cleared.
//  States: IDLE, BEAT, GAP, RESP.
//  IDLE: on s_cyc&s_stb, latch adr/dat/sel/we.
//   - sel[3:2]!=0: go to BEAT with half=HI.
//   - else sel[1:0]!=0: go to BEAT with half=LO.
//   - sel==0: go to RESP (ack, no memory access).
//  BEAT: m_cyc=m_stb=1; m_sel = HI ? sel[3:2] : sel[1:0]; m_dat_o = HI ? dat[31:16] : dat[15:0]; m_we=we.
//   - Watchdog counts from 0 each beat. On m_ack_i: reads capture m_dat_i into s_wb_dat_o[31:16] (HI) or [15:0] (LO).
//   - Next: GAP if HI and sel[1:0]!=0, else RESP.
//   - If the count reaches TIMEOUT without ack: go to RESP with err flagged; m_cyc/m_stb drop next cycle.
//  GAP: one cycle, m_cyc=m_stb=0. Any m_ack_i is discarded (a registered-ack responder acks twice). Next: BEAT, half=LO.
//  RESP: one cycle. s_ack_o=1, or s_err_o=1 on timeout, never both. m_stb=0. m_ack_i discarded. Next: IDLE.
//   - Unread halves of s_wb_dat_o are 0 on reads; s_wb_dat_o holds until the next read capture.
//  m_wb_ack_i outside BEAT is always ignored. s_stb deasserted while busy is ignored (no abort); the initiator must hold until ack/err.
//  Latency (1-cycle-ack memory), counted from request cycle to s_ack cycle: full word 6 cycles, single half 3, sel==0 1.
//  Back-to-back: a request presented in the cycle after RESP is accepted; minimum one IDLE cycle between transfers.
// STRUCTURE
//  wb_bridge_defs.vh (shared): state encodings ST_IDLE/ST_BEAT/ST_GAP/ST_RESP, HALF_HI=0/HALF_LO=1.
//  Sub-module wb_watchdog(clk_i, rst_i, clr, run, expired), parameterised TIMEOUT/TW; reused by other bridges.
//  Top: FSM, request latch, read-data register.
// TESTING (bench pairs the bridge with a 4K x 16 registered-ack RAM model and a stall-capable memory BFM)
//  1. Write adr=0x10, dat=0xDEADBEEF, sel=4'hF -> RAM[0x10]=0xDEAD, RAM[0x12]=0xBEEF; s_ack 6 cycles after request; 2 m_stb beats.
//  2. Read back adr=0x10, sel=4'hF -> s_dat_o=0xDEADBEEF, single s_ack, no s_err; GAP-cycle spurious ack ignored.
//  3. Write sel=4'h3, dat=0x12345678 at 0x20 -> one beat to 0x22, m_sel=2'b11, data 0x5678; 0x20 untouched; ack in 3 cycles.
//  4. sel=4'h0 -> no m_cyc/m_stb activity; s_ack in the next cycle.
//  5. BFM withholds ack, TIMEOUT=15 -> s_err pulse 17 cycles after request, s_ack stays 0, m_cyc drops; next read succeeds.
//  6. Assert rst_i=0 during the LO beat -> all outputs 0 immediately; after release, IDLE accepts a new request normally.

Source files
------------

// File: rtl/wb32to16_bridge_pkg.sv
// Shared types for the 32-to-16 Wishbone bridge: FSM encodings, half selector, latched request.
package wb32to16_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_GAP  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic HALF_HI = 1'b0;
  localparam logic HALF_LO = 1'b1;

  typedef struct packed {
    logic [29:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } req_t;

  // Big-endian halfword address: high half at +0, low half at +2.
  function automatic logic [31:0] beat_adr(input logic [29:0] word_adr, input logic half);
    return {word_adr, half, 1'b0};
  endfunction

endpackage

// File: rtl/wb32to16_bridge_watchdog.sv
// Beat watchdog: counts cycles while run is high, expired once the count reaches TIMEOUT.
// clr restarts the count; TIMEOUT=0 never expires.
module wb_watchdog #(
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && run && !clr && (cnt_q == LIMIT);

endmodule

// File: rtl/wb32to16_bridge.sv
// Splits 32-bit Wishbone accesses into up to two big-endian 16-bit beats, one transfer outstanding.
// Full word 6 cycles, single half 3, sel==0 1 (1-cycle-ack memory); hung beats become an error response.
module wb32to16_bridge
  import wb32to16_bridge_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] s_wb_adr_i,
  input  logic [31:0] s_wb_dat_i,
  output logic [31:0] s_wb_dat_o,
  input  logic [3:0]  s_wb_sel_i,
  input  logic        s_wb_we_i,
  input  logic        s_wb_cyc_i,
  input  logic        s_wb_stb_i,
  output logic        s_wb_ack_o,
  output logic        s_wb_err_o,
  output logic [31:0] m_wb_adr_o,
  output logic [15:0] m_wb_dat_o,
  input  logic [15:0] m_wb_dat_i,
  output logic [1:0]  m_wb_sel_o,
  output logic        m_wb_we_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  input  logic        m_wb_ack_i
);

  state_t      state_q, state_d;
  logic        half_q, half_d;
  req_t        req_q;
  logic        err_q;
  logic [31:0] s_dat_q;
  logic        s_req;
  logic        wd_expired;
  logic        unused_adr_lsb;

  assign s_req          = s_wb_cyc_i & s_wb_stb_i;
  assign unused_adr_lsb = ^s_wb_adr_i[1:0];
  assign s_wb_dat_o     = s_dat_q;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (state_q != ST_BEAT),
    .run     (state_q == ST_BEAT),
    .expired (wd_expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      half_q  <= HALF_HI;
      req_q   <= '0;
      err_q   <= 1'b0;
      s_dat_q <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      case (state_q)
        ST_IDLE: begin
          if (s_req) begin
            req_q <= '{adr: s_wb_adr_i[31:2], dat: s_wb_dat_i, sel: s_wb_sel_i, we: s_wb_we_i};
            err_q <= 1'b0;
            // Unread halves of a read must come back as zero.
            if (!s_wb_we_i) s_dat_q <= '0;
          end
        end
        ST_BEAT: begin
          if (m_wb_ack_i) begin
            if (!req_q.we) begin
              if (half_q == HALF_HI) s_dat_q[31:16] <= m_wb_dat_i;
              else                   s_dat_q[15:0]  <= m_wb_dat_i;
            end
          end else if (wd_expired) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    case (state_q)
      ST_IDLE: begin
        if (s_req) begin
          if (|s_wb_sel_i[3:2]) begin
            state_d = ST_BEAT;
            half_d  = HALF_HI;
          end else if (|s_wb_sel_i[1:0]) begin
            state_d = ST_BEAT;
            half_d  = HALF_LO;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_BEAT: begin
        // A real ack wins over a simultaneous watchdog expiry.
        if (m_wb_ack_i) begin
          if ((half_q == HALF_HI) && (|req_q.sel[1:0])) state_d = ST_GAP;
          else                                           state_d = ST_RESP;
        end else if (wd_expired) begin
          state_d = ST_RESP;
        end
      end
      ST_GAP: begin
        state_d = ST_BEAT;
        half_d  = HALF_LO;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_wb_ack_o = 1'b0;
    s_wb_err_o = 1'b0;
    m_wb_adr_o = '0;
    m_wb_dat_o = '0;
    m_wb_sel_o = '0;
    m_wb_we_o  = 1'b0;
    m_wb_cyc_o = 1'b0;
    m_wb_stb_o = 1'b0;
    case (state_q)
      ST_BEAT: begin
        m_wb_cyc_o = 1'b1;
        m_wb_stb_o = 1'b1;
        m_wb_we_o  = req_q.we;
        m_wb_adr_o = beat_adr(req_q.adr, half_q);
        m_wb_sel_o = (half_q == HALF_HI) ? req_q.sel[3:2] : req_q.sel[1:0];
        m_wb_dat_o = (half_q == HALF_HI) ? req_q.dat[31:16] : req_q.dat[15:0];
      end
      ST_RESP: begin
        s_wb_ack_o = !err_q;
        s_wb_err_o = err_q;
      end
      default: ;
    endcase
  end

endmodule
